uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing one UART transmitter (tx) between NREQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// A packet lock keeps the grant on one source until it sends a byte flagged last.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int BUSY_TO = 8
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              locked,
    output logic              active,
    output logic              err_to
);

    localparam logic [1:0] ARB       = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam int CW = ($clog2(BUSY_TO) < 1) ? 1 : $clog2(BUSY_TO);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic           last_q;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] cand;
    logic [7:0]     pick_data;
    logic           pick_last;

    // Search starts one past the last served source, so grant_id doubles as the RR pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = grant_id;
        cand       = '0;
        if (locked) begin
            pick_found = req_valid[grant_id];
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                cand = IDW'((int'(grant_id) + i) % NREQ);
                if (!pick_found && req_valid[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
        pick_data = 8'h00;
        pick_last = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_idx == IDW'(j)) begin
                pick_data = req_data[8*j +: 8];
                pick_last = req_last[j];
            end
        end
    end

    assign active = (state != ARB);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= ARB;
            cnt       <= '0;
            last_q    <= 1'b0;
            req_ready <= '0;
            tx_din    <= 8'h00;
            tx_wr_en  <= 1'b0;
            grant_id  <= '0;
            locked    <= 1'b0;
            err_to    <= 1'b0;
        end else begin
            err_to <= 1'b0;
            case (state)
                ARB: begin
                    if (!tx_busy && pick_found) begin
                        tx_din    <= pick_data;
                        tx_wr_en  <= 1'b1;
                        req_ready <= NREQ'(1) << pick_idx;
                        grant_id  <= pick_idx;
                        last_q    <= pick_last;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_wr_en  <= 1'b0;
                    req_ready <= '0;
                    cnt       <= '0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A timeout drops any pending lock so a dead tx cannot pin one source.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(BUSY_TO - 1)) begin
                        err_to <= 1'b1;
                        locked <= 1'b0;
                        state  <= ARB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        locked <= !last_q;
                        state  <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source byte queues drive the DUT,
// a monitor pops hand-ordered expected writes whenever tx_wr_en is seen.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int FRAME = 10;

    logic              clk_50m = 1'b0;
    logic              rst     = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              tx_busy;
    logic [IDW-1:0]    grant_id;
    logic              locked;
    logic              active;
    logic              err_to;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .BUSY_TO(8)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .locked    (locked),
        .active    (active),
        .err_to    (err_to)
    );

    always #10 clk_50m = ~clk_50m;

    int checks = 0;
    int errors = 0;
    int writes = 0;

    logic [9:0] expq[$];
    logic [9:0] e;

    logic [7:0] srcData [NREQ][16];
    logic       srcLast [NREQ][16];
    int head  [NREQ] = '{default: 0};
    int tail  [NREQ] = '{default: 0};
    int limit [NREQ] = '{default: 16};

    // Transmitter model: busy for FRAME cycles after each accepted write.
    int   busyCnt   = 0;
    logic txEnable  = 1'b1;
    logic forceBusy = 1'b0;

    always @(posedge clk_50m) begin
        if (tx_wr_en && txEnable) busyCnt <= FRAME;
        else if (busyCnt > 0)     busyCnt <= busyCnt - 1;
    end

    assign tx_busy = forceBusy || (busyCnt != 0);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [7:0] d, input logic last);
        srcData[src][tail[src]] = d;
        srcLast[src][tail[src]] = last;
        tail[src]++;
    endtask

    task automatic expectWrite(input int src, input logic [7:0] d);
        expq.push_back({2'(src), d});
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic waitWrite(input string name, output int n);
        n = 0;
        while (!tx_wr_en && n < 200) begin
            tick();
            n++;
        end
        checkOutput({name, "_write_seen"}, 32'(n < 200), 1);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (!(active == 1'b0 && tx_busy == 1'b0 && expq.size() == 0) && n < 2000) begin
            tick();
            n++;
        end
        checkOutput({name, "_idle_reached"}, 32'(n < 2000), 1);
    endtask

    task automatic waitLocked(input string name);
        int n = 0;
        while (!locked && n < 100) begin
            tick();
            n++;
        end
        checkOutput({name, "_lock_taken"}, 32'(n < 100), 1);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_tx_din"},    32'(tx_din), 0);
        checkOutput({name, "_tx_wr_en"},  32'(tx_wr_en), 0);
        checkOutput({name, "_req_ready"}, 32'(req_ready), 0);
        checkOutput({name, "_grant_id"},  32'(grant_id), 0);
        checkOutput({name, "_locked"},    32'(locked), 0);
        checkOutput({name, "_active"},    32'(active), 0);
        checkOutput({name, "_err_to"},    32'(err_to), 0);
    endtask

    // Source driver: pop on accepted byte, present the next one half a cycle later.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk_50m);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) head[i]++;
                if (head[i] < tail[i] && head[i] < limit[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = srcData[i][head[i]];
                    req_last[i]        = srcLast[i][head[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every write must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk_50m);
            if (!rst && tx_wr_en) begin
                writes++;
                checkOutput("tx_idle_at_write", 32'(tx_busy), 0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got din 0x%0h grant %0d, expected no write", tx_din, grant_id);
                end else begin
                    e = expq.pop_front();
                    checkOutput("write_din",   32'(tx_din), 32'(e[7:0]));
                    checkOutput("write_grant", 32'(grant_id), 32'(e[9:8]));
                    checkOutput("write_ready", 32'(req_ready), 32'(4'b0001 << e[9:8]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int w0;

        rst = 1'b1;
        repeat (3) tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        tick();

        // Single byte from source 0
        applyStimulus(0, 8'hA5, 1'b1);
        expectWrite(0, 8'hA5);
        waitWrite("single", n);
        checkOutput("single_latency", 32'(n), 1);
        waitIdle("single");
        checkOutput("single_locked_after", 32'(locked), 0);

        // Round robin from grant 0: 1,2,0,1,2,0
        applyStimulus(0, 8'h10, 1'b1); applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(1, 8'h20, 1'b1); applyStimulus(1, 8'h21, 1'b1);
        applyStimulus(2, 8'h30, 1'b1); applyStimulus(2, 8'h31, 1'b1);
        expectWrite(1, 8'h20); expectWrite(2, 8'h30); expectWrite(0, 8'h10);
        expectWrite(1, 8'h21); expectWrite(2, 8'h31); expectWrite(0, 8'h11);
        waitIdle("rr");
        checkOutput("rr_grant_end", 32'(grant_id), 0);
        checkOutput("rr_locked_end", 32'(locked), 0);

        // Packet lock: src2 sends three bytes while src1 waits
        applyStimulus(2, 8'h40, 1'b0);
        applyStimulus(2, 8'h41, 1'b0);
        applyStimulus(2, 8'h42, 1'b1);
        expectWrite(2, 8'h40); expectWrite(2, 8'h41); expectWrite(2, 8'h42);
        expectWrite(1, 8'h50);
        waitWrite("lock_first", n);
        applyStimulus(1, 8'h50, 1'b1);
        tick();
        waitLocked("lock");
        waitIdle("lock");
        checkOutput("lock_grant_end", 32'(grant_id), 1);
        checkOutput("lock_locked_end", 32'(locked), 0);

        // Lock stall: src3 locked but its next byte withheld, src0 must wait
        limit[3] = 1;
        applyStimulus(3, 8'h60, 1'b0);
        applyStimulus(3, 8'h61, 1'b1);
        expectWrite(3, 8'h60); expectWrite(3, 8'h61); expectWrite(0, 8'h70);
        waitWrite("stall_first", n);
        tick();
        waitLocked("stall");
        applyStimulus(0, 8'h70, 1'b1);
        w0 = writes;
        repeat (50) tick();
        checkOutput("stall_no_write", 32'(writes - w0), 0);
        checkOutput("stall_locked", 32'(locked), 1);
        checkOutput("stall_grant", 32'(grant_id), 3);
        limit[3] = 16;
        waitIdle("stall");
        checkOutput("stall_grant_end", 32'(grant_id), 0);
        checkOutput("stall_locked_end", 32'(locked), 0);

        // Timeout: tx never goes busy; a non-last byte must not leave a lock behind
        txEnable = 1'b0;
        applyStimulus(1, 8'h80, 1'b0);
        expectWrite(1, 8'h80);
        waitWrite("timeout", n);
        n = 0;
        while (!err_to && n < 50) begin
            tick();
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 9);
        checkOutput("timeout_active", 32'(active), 0);
        checkOutput("timeout_locked", 32'(locked), 0);
        checkOutput("timeout_grant", 32'(grant_id), 1);
        tick();
        checkOutput("timeout_pulse_width", 32'(err_to), 0);
        txEnable = 1'b1;

        // Reset while a frame is in progress
        applyStimulus(2, 8'h90, 1'b1);
        expectWrite(2, 8'h90);
        waitWrite("midreset", n);
        repeat (3) tick();
        checkOutput("midreset_active_before", 32'(active), 1);
        forceBusy = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checkResetOutputs("midreset");
        applyStimulus(0, 8'hA0, 1'b1);
        expectWrite(0, 8'hA0);
        w0 = writes;
        repeat (20) tick();
        checkOutput("midreset_no_write_while_busy", 32'(writes - w0), 0);
        checkOutput("midreset_active_while_busy", 32'(active), 0);
        forceBusy = 1'b0;
        waitWrite("midreset_after", n);
        checkOutput("midreset_latency", 32'(n), 1);
        waitIdle("midreset");

        checkOutput("scoreboard_drained", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
